usb_bulk_in_tx: RTL and testbench
=================================

# usb_bulk_in_tx

Bulk-IN endpoint transmitter sitting directly downstream of the endpoint byte queue. It drains the queue into a local packet buffer of up to MAX_PKT bytes. On each IN token it emits either a DATA0/DATA1 packet (PID, payload, CRC16) or a NAK byte stream toward the serial interface engine. The buffer is held until ACK so that a handshake timeout retransmits the same packet with the same PID.

## Interface
- MAX_PKT, 64, maximum payload bytes per packet (1..1023)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- q_data  in  8  queue read data; valid the cycle after q_read is high
- q_empty  in  1  queue empty flag
- q_read  out  1  queue read strobe; one-cycle pulse, never high two cycles in a row
- in_token  in  1  one-cycle pulse: IN token addressed to this endpoint
- ack_rcvd  in  1  one-cycle pulse: host ACK received for the last DATA packet
- hs_timeout  in  1  one-cycle pulse: no handshake within the bus turnaround window
- toggle_clr  in  1  pulse: force the next DATA PID to DATA0 (SET_CONFIG / CLEAR_FEATURE)
- tx_data  out  8  outgoing byte
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  SIE accepts the byte in this cycle when tx_valid is high
- tx_last  out  1  marks the final byte of the packet
- busy  out  1  high from the first tx byte through handshake resolution

## Operation
- States: FILL, RD_WAIT, SEND_PID, SEND_DATA, SEND_CRC_LO, SEND_CRC_HI, SEND_NAK, WAIT_HS.
- FILL:
  - if the buffer is not committed, cnt < MAX_PKT and !q_empty: pulse q_read, go to RD_WAIT.
  - RD_WAIT stores q_data at buf[cnt], increments cnt, then returns to FILL.
- in_token in FILL, or latched during RD_WAIT and serviced after the byte is stored:
  - if cnt > 0, commit the buffer and go to SEND_PID.
  - otherwise go to SEND_NAK.
- SEND_PID: byte 0xC3 (DATA0) or 0x4B (DATA1), selected by the toggle bit.
- SEND_DATA: buf[0..cnt-1] in order.
- SEND_CRC_LO / SEND_CRC_HI: CRC16 low byte, then high byte; tx_last is high on the high byte. Then go to WAIT_HS.
- CRC16:
  - polynomial x^16+x^15+x^2+1, LSB-first (reflected 0xA001), seed 0xFFFF.
  - covers payload bytes only; the transmitted value is the one's complement.
- SEND_NAK: single byte 0x5A with tx_last high, then back to FILL. Buffer, toggle and cnt are unchanged.
- WAIT_HS:
  - ack_rcvd: flip toggle, cnt <= 0, uncommit, go to FILL.
  - hs_timeout: keep buffer, toggle and cnt; go to FILL with the buffer still committed. The next in_token resends an identical packet.
  - ack_rcvd and hs_timeout in the same cycle: ACK wins.
- in_token during SEND_* or WAIT_HS is ignored.
- toggle_clr takes effect in any state. It does not alter a packet already in flight: the PID byte is latched at SEND_PID entry.
- A committed buffer blocks all queue reads, so queue order is preserved across retransmits.

## Timing
- Reset values: q_read 0, tx_valid 0, tx_data 0x00, tx_last 0, busy 0, toggle 0 (DATA0), cnt 0, state FILL, buffer uncommitted.
- Fill rate: one queue byte per 2 cycles (q_read high, RD_WAIT). This satisfies the queue's edge-detected strobe.
- in_token to first tx_valid: 1 cycle from FILL; 2 cycles if the token lands in the q_read cycle.
- tx handshake:
  - tx_data and tx_last stay stable while tx_valid && !tx_ready.
  - the next byte is presented in the cycle after acceptance, so back-to-back at full rate is allowed.
  - tx_valid never drops mid-packet.
- CRC is updated on byte acceptance only. The CRC output is registered and ready when SEND_CRC_LO is entered.
- busy rises with SEND_PID or SEND_NAK entry and falls the cycle after leaving WAIT_HS or the NAK byte is accepted.
- Reset asserted mid-packet: outputs clear asynchronously. Buffer contents and any queue bytes already read are discarded.

## Configuration
- USB_TX_ZLP_EN defined:
  - after an ACKed packet of exactly MAX_PKT bytes, a flag is set.
  - if the queue is empty when the next in_token arrives, a zero-length packet is sent: PID, 0x00, 0x00, tx_last on the last byte. The toggle advances on its ACK.
  - the flag clears on that ACK or on any non-empty packet.
- USB_TX_ZLP_EN undefined: no flag exists; the empty case always sends NAK.

## Structure
- Shared package usb_pkg:
  - PID constants PID_DATA0 0xC3, PID_DATA1 0x4B, PID_NAK 0x5A.
  - CRC16_SEED 0xFFFF, CRC16_POLY_REFL 0xA001.
  - tx state encoding.
- Sub-module usb_crc16: byte-wide combinational CRC step with a registered accumulator. Ports: clr, en, data[7:0], crc[15:0]. This block is reused by the OUT receiver.

## Test plan
- Queue empty, in_token -> single byte 0x5A with tx_last; no q_read pulses; toggle stays 0.
- Queue holds 0x00 0x01 0x02 0x03, in_token, ACK:
  - stream is C3 00 01 02 03 plus two CRC bytes matching the reference model, tx_last on the final byte.
  - next packet uses PID 0x4B.
- Same packet, then hs_timeout, then in_token -> byte-identical resend with PID 0xC3; q_read stays low throughout.
- Queue holds 70 bytes, MAX_PKT 64 -> first packet carries 64 bytes; after ACK the second packet (DATA1) carries 6 bytes.
- tx_ready low for 3 cycles mid-payload -> tx_data and tx_valid held; no byte skipped or duplicated; CRC unchanged.
- USB_TX_ZLP_EN: 64 bytes, ACK, queue empty, in_token -> 4B 00 00 with tx_last on the last byte. Without the macro -> 5A.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB definitions: PID bytes, CRC16 constants, bulk-IN transmitter state
// encoding and the byte-wide CRC16 step used by the IN transmitter and OUT receiver.
package usb_pkg;

  localparam logic [7:0]  PID_DATA0       = 8'hC3;
  localparam logic [7:0]  PID_DATA1       = 8'h4B;
  localparam logic [7:0]  PID_NAK         = 8'h5A;
  localparam logic [15:0] CRC16_SEED      = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_RD_WAIT,
    ST_SEND_PID,
    ST_SEND_DATA,
    ST_SEND_CRC_LO,
    ST_SEND_CRC_HI,
    ST_SEND_NAK,
    ST_WAIT_HS
  } tx_state_e;

  // Reflected CRC16: fold the byte into the low end, then shift out eight bits.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-wide CRC16 accumulator (USB data CRC). clr reseeds, en folds in one byte;
// crc holds the raw accumulator, the transmitted value is its complement.
module usb_crc16
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc <= CRC16_SEED;
    end else if (clr) begin
      crc <= CRC16_SEED;
    end else if (en) begin
      crc <= crc16_step(crc, data);
    end
  end

endmodule

// File: rtl/usb_bulk_in_tx.sv
// Bulk-IN endpoint transmitter: fills a packet buffer from the endpoint queue and answers
// IN tokens with DATA0/DATA1 or NAK. Optional zero-length packets via USB_TX_ZLP_EN.
module usb_bulk_in_tx
  import usb_pkg::*;
#(
  parameter int unsigned MAX_PKT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] q_data,
  input  logic       q_empty,
  output logic       q_read,
  input  logic       in_token,
  input  logic       ack_rcvd,
  input  logic       hs_timeout,
  input  logic       toggle_clr,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_last,
  output logic       busy
);

  localparam int unsigned CW = $clog2(MAX_PKT + 1);
  localparam int unsigned AW = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PKT);

  tx_state_e     state_q;
  logic [7:0]    mem_q [2**AW];
  logic [CW-1:0] cnt_q, idx_q;
  logic          committed_q, toggle_q, tok_pend_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q, tx_last_q, busy_q;
  logic [15:0]   crc;
  logic          accept, ack_evt, zlp_go;
  logic [7:0]    pid_next;

  assign accept   = tx_valid_q && tx_ready;
  assign ack_evt  = (state_q == ST_WAIT_HS) && ack_rcvd;
  assign pid_next = (toggle_q && !toggle_clr) ? PID_DATA1 : PID_DATA0;
  // Combinational strobe: the queue answers one cycle later, giving one byte per two cycles.
  assign q_read   = (state_q == ST_FILL) && !committed_q && (cnt_q < CNT_MAX) && !q_empty;

  usb_crc16 u_crc (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == ST_SEND_PID),
    .en   ((state_q == ST_SEND_DATA) && accept),
    .data (tx_data_q),
    .crc  (crc)
  );

`ifdef USB_TX_ZLP_EN
  logic zlp_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zlp_q <= 1'b0;
    end else if (ack_evt) begin
      zlp_q <= (cnt_q == CNT_MAX);
    end else if ((state_q == ST_SEND_PID) && (cnt_q != '0)) begin
      zlp_q <= 1'b0;
    end
  end
  assign zlp_go = zlp_q && q_empty;
`else
  assign zlp_go = 1'b0;
`endif

  // NOTE: packet memory has no reset; cnt_q alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (state_q == ST_RD_WAIT) begin
      mem_q[cnt_q[AW-1:0]] <= q_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_FILL;
      cnt_q       <= '0;
      idx_q       <= '0;
      committed_q <= 1'b0;
      toggle_q    <= 1'b0;
      tok_pend_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      tx_last_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (toggle_clr) toggle_q <= 1'b0;
      case (state_q)
        ST_FILL: begin
          if (q_read) begin
            tok_pend_q <= in_token;
            state_q    <= ST_RD_WAIT;
          end else if (in_token) begin
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            idx_q      <= '0;
            if (committed_q || (cnt_q != '0) || zlp_go) begin
              committed_q <= 1'b1;
              tx_data_q   <= pid_next;
              state_q     <= ST_SEND_PID;
            end else begin
              tx_data_q <= PID_NAK;
              tx_last_q <= 1'b1;
              state_q   <= ST_SEND_NAK;
            end
          end
        end
        ST_RD_WAIT: begin
          cnt_q      <= cnt_q + CW'(1);
          tok_pend_q <= 1'b0;
          if (in_token || tok_pend_q) begin
            committed_q <= 1'b1;
            tx_data_q   <= pid_next;
            tx_valid_q  <= 1'b1;
            busy_q      <= 1'b1;
            idx_q       <= '0;
            state_q     <= ST_SEND_PID;
          end else begin
            state_q <= ST_FILL;
          end
        end
        ST_SEND_PID, ST_SEND_DATA: begin
          if (accept) begin
            if (idx_q == cnt_q) begin
              state_q <= ST_SEND_CRC_LO;
            end else begin
              tx_data_q <= mem_q[idx_q[AW-1:0]];
              idx_q     <= idx_q + CW'(1);
              state_q   <= ST_SEND_DATA;
            end
          end
        end
        ST_SEND_CRC_LO: begin
          if (accept) begin
            tx_last_q <= 1'b1;
            state_q   <= ST_SEND_CRC_HI;
          end
        end
        ST_SEND_CRC_HI: begin
          if (accept) begin
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            state_q    <= ST_WAIT_HS;
          end
        end
        ST_SEND_NAK: begin
          if (accept) begin
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= ST_FILL;
          end
        end
        ST_WAIT_HS: begin
          if (ack_rcvd) begin
            if (!toggle_clr) toggle_q <= !toggle_q;
            cnt_q       <= '0;
            committed_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_FILL;
          end else if (hs_timeout) begin
            busy_q  <= 1'b0;
            state_q <= ST_FILL;
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  // NOTE: always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    tx_data = tx_data_q;
    if (state_q == ST_SEND_CRC_LO) begin
      tx_data = ~crc[7:0];
    end else if (state_q == ST_SEND_CRC_HI) begin
      tx_data = ~crc[15:8];
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_last  = tx_last_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_usb_bulk_in_tx.sv
// Scoreboard bench for usb_bulk_in_tx: a packet-level model predicts each tx byte stream,
// a negedge monitor pops and compares accepted bytes. Honors USB_TX_ZLP_EN.
module tb_usb_bulk_in_tx;

  localparam int MAX = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] q_data = 8'h00;
  logic       q_empty;
  logic       q_read;
  logic       in_token, ack_rcvd, hs_timeout, toggle_clr;
  logic [7:0] tx_data;
  logic       tx_valid, tx_last, busy;
  logic       tx_ready = 1'b1;

  usb_bulk_in_tx #(.MAX_PKT(MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .q_data     (q_data),
    .q_empty    (q_empty),
    .q_read     (q_read),
    .in_token   (in_token),
    .ack_rcvd   (ack_rcvd),
    .hs_timeout (hs_timeout),
    .toggle_clr (toggle_clr),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_last    (tx_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Endpoint queue: stimulus owns the write index, the responder owns the read index.
  logic [7:0] src_mem [4096];
  int src_wr = 0;
  int src_rd = 0;
  int rd_cnt = 0;
  int cyc    = 0;
  assign q_empty = (src_rd == src_wr);

  // Expected tx bytes {last, data}: stimulus pushes, monitor pops.
  logic [8:0] exp_mem [8192];
  int exp_wr = 0;
  int exp_rd = 0;

  // Packet-level reference model.
  logic [7:0] m_src[$];
  logic [7:0] m_pkt[$];
  bit m_committed = 0;
  bit m_toggle    = 0;
  bit m_zlp       = 0;

  int  stall_start = -100;
  bit  rnd_ready   = 0;
  int  held_cnt    = 0;
  bit  stalled     = 0;
  bit  prev_rd     = 0;
  logic [9:0] prev_hold = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit last, input logic [7:0] d);
    exp_mem[exp_wr] = {last, d};
    exp_wr++;
  endtask

  task automatic push_src(input logic [7:0] d);
    src_mem[src_wr] = d;
    m_src.push_back(d);
    src_wr++;
  endtask

  // Queue responder: data appears the cycle after the strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && q_read) begin
      q_data <= src_mem[src_rd];
      src_rd <= src_rd + 1;
      rd_cnt <= rd_cnt + 1;
    end
  end

  // SIE back-pressure: directed stall window, optional random, otherwise always ready.
  always @(posedge clk) begin
    #1;
    if (cyc >= stall_start && cyc < stall_start + 3) tx_ready = 1'b0;
    else if (rnd_ready) tx_ready = ($urandom_range(0, 3) != 0);
    else tx_ready = 1'b1;
  end

  // Monitor: compare each accepted byte, hold stability and strobe shape.
  always @(negedge clk) begin
    if (rst) begin
      if (stalled) begin
        check("hold_stable", {22'd0, tx_valid, tx_last, tx_data}, {22'd0, prev_hold});
        held_cnt++;
      end
      if (tx_valid) check("busy_with_valid", busy, 1);
      if (q_read) check("q_read_single_pulse", prev_rd, 0);
      prev_rd = q_read;
      if (tx_valid && tx_ready) begin
        stalled = 0;
        if (exp_rd == exp_wr) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h last %0b, expected nothing", tx_data, tx_last);
        end else begin
          check("tx_byte", {23'd0, tx_last, tx_data}, {23'd0, exp_mem[exp_rd]});
          exp_rd++;
        end
      end else begin
        stalled   = tx_valid;
        prev_hold = {tx_valid, tx_last, tx_data};
      end
    end
  end

  // Predict the response to an IN token, then issue it and check first-byte latency.
  task automatic send_token(output bit is_data);
    logic [15:0] r;
    bit fb;
    bit zlp_ok;
    if (!m_committed)
      while (m_pkt.size() < MAX && m_src.size() > 0) m_pkt.push_back(m_src.pop_front());
    zlp_ok = 0;
`ifdef USB_TX_ZLP_EN
    zlp_ok = m_zlp && (m_pkt.size() == 0);
`endif
    is_data = m_committed || (m_pkt.size() > 0) || zlp_ok;
    if (is_data) begin
      if (m_pkt.size() > 0) m_zlp = 0;
      m_committed = 1;
      push_exp(1'b0, m_toggle ? 8'h4B : 8'hC3);
      r = 16'hFFFF;
      foreach (m_pkt[i]) begin
        push_exp(1'b0, m_pkt[i]);
        for (int b = 0; b < 8; b++) begin
          fb = r[0] ^ m_pkt[i][b];
          r  = r >> 1;
          if (fb) r = r ^ 16'hA001;
        end
      end
      r = ~r;
      push_exp(1'b0, r[7:0]);
      push_exp(1'b1, r[15:8]);
    end else begin
      push_exp(1'b1, 8'h5A);
    end
    tick();
    in_token = 1'b1;
    tick();
    in_token = 1'b0;
    check("token_to_valid", tx_valid, 1);
  endtask

  task automatic wait_tx_done(input string name);
    int n;
    n = 0;
    while (exp_rd != exp_wr && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (exp_rd != exp_wr) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: %0d bytes still outstanding, expected 0", name, exp_wr - exp_rd);
      finish_run();
    end
  endtask

  // kind: 0 ACK, 1 timeout, 2 both in the same cycle (ACK wins)
  task automatic handshake(input int kind);
    tick();
    ack_rcvd   = (kind != 1);
    hs_timeout = (kind != 0);
    tick();
    ack_rcvd   = 1'b0;
    hs_timeout = 1'b0;
    if (kind != 1) begin
      m_toggle = !m_toggle;
      m_zlp    = (m_pkt.size() == MAX);
      m_pkt.delete();
      m_committed = 0;
    end
  endtask

  task automatic fill_wait();
    repeat (2 * MAX + 10) tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit is_data;
    int r0, h0, n;
    rst = 1'b0;
    in_token = 1'b0; ack_rcvd = 1'b0; hs_timeout = 1'b0; toggle_clr = 1'b0;
    #23;
    check("rst_q_read", q_read, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_tx_last", tx_last, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Empty queue: NAK, no reads.
    r0 = rd_cnt;
    send_token(is_data);
    wait_tx_done("nak");
    repeat (3) tick();
    check("nak_no_reads", rd_cnt, r0);
    check("nak_busy_low", busy, 0);

    // 00 01 02 03 as DATA0, ACK.
    for (int i = 0; i < 4; i++) push_src(8'(i));
    fill_wait();
    send_token(is_data);
    wait_tx_done("pkt_0123");
    handshake(0);

    // DATA1 packet, timeout, identical resend with no queue reads meanwhile.
    for (int i = 0; i < 4; i++) push_src(8'($urandom));
    fill_wait();
    send_token(is_data);
    wait_tx_done("pkt_first");
    handshake(1);
    r0 = rd_cnt;
    for (int i = 0; i < 5; i++) push_src(8'($urandom));
    fill_wait();
    send_token(is_data);
    wait_tx_done("pkt_resend");
    check("resend_no_reads", rd_cnt, r0);
    handshake(2);

    // 70 queued bytes split into 64 + rest (including the 5 left over above).
    for (int i = 0; i < 70; i++) push_src(8'($urandom));
    fill_wait();
    send_token(is_data);
    wait_tx_done("pkt_max");
    handshake(0);
    fill_wait();
    send_token(is_data);
    wait_tx_done("pkt_tail");
    handshake(0);

    // Three-cycle stall mid-payload.
    for (int i = 0; i < 10; i++) push_src(8'($urandom));
    fill_wait();
    h0 = held_cnt;
    stall_start = cyc + 5;
    send_token(is_data);
    wait_tx_done("pkt_stall");
    check("stall_held_cycles", (held_cnt - h0) >= 3, 1);
    handshake(0);

    // Full packet, ACK, empty queue: ZLP with the macro, NAK without.
    for (int i = 0; i < MAX; i++) push_src(8'($urandom));
    fill_wait();
    send_token(is_data);
    wait_tx_done("pkt_full");
    handshake(0);
    fill_wait();
    send_token(is_data);
    wait_tx_done("pkt_after_full");
    if (is_data) handshake(0);

    // Randomized traffic.
    for (int it = 0; it < 25; it++) begin
      n = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 80));
      for (int i = 0; i < n; i++) push_src(8'($urandom));
      fill_wait();
      if ($urandom_range(0, 4) == 0) begin
        tick(); toggle_clr = 1'b1;
        tick(); toggle_clr = 1'b0;
        m_toggle = 0;
      end
      rnd_ready = ($urandom_range(0, 1) == 1);
      send_token(is_data);
      wait_tx_done("rand_pkt");
      if (is_data) begin
        if ($urandom_range(0, 2) == 0) begin
          tick(); in_token = 1'b1;
          tick(); in_token = 1'b0;
        end
        handshake(int'($urandom_range(0, 2)));
      end
      rnd_ready = 0;
    end

    repeat (10) tick();
    check("no_bytes_outstanding", exp_rd, exp_wr);
    check("idle_tx_valid", tx_valid, 0);
    finish_run();
  end

endmodule
